disp_scheduler: RTL and testbench

//  Round-robin scheduler that shares the 4-digit signed-decimal 7-seg display between NUM_SRC requesters.

---
 rtl/disp_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/disp_scheduler.sv | 125 ++++++++++++
 tb/tb_disp_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display scheduler: FSM encoding and display data width.
package disp_pkg;

   localparam int DISP_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, scanning upward with wrap.
module rr_arbiter
   import disp_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any_req
);

   // Walk the offsets from farthest to nearest so the nearest hit is the final assignment.
   always_comb begin
      gnt_idx = '0;
      any_req = |req;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_SRC]) begin
            gnt_idx = SRC_W'((int'(ptr) + k) % NUM_SRC);
         end
      end
   end

endmodule

// File: rtl/disp_scheduler.sv
// Round-robin owner of the 7-seg display: grants a source, strobes its value in, dwells, rotates.
// Optional DISP_SCHED_PAUSE_EN adds a pause input that freezes the dwell and blocks new grants.
module disp_scheduler
   import disp_pkg::*;
#(
   parameter  int NUM_SRC     = 4,
   parameter  int HOLD_CYCLES = 100_000_000,
   localparam int SRC_W       = $clog2(NUM_SRC),
   localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                       disp_clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [DISP_DW*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]         src_ack,
   output logic [DISP_DW-1:0]         disp_din,
   output logic                       disp_en,
   output logic [SRC_W-1:0]           cur_src
`ifdef DISP_SCHED_PAUSE_EN
   ,
   input  logic                       pause
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_e               state_q, state_d;
   logic [SRC_W-1:0]     cur_src_q, cur_src_d;
   logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     timer_q, timer_d;
   logic [DISP_DW-1:0]   din_q, din_d;
   logic                 en_q, en_d;
   logic [NUM_SRC-1:0]   ack_q, ack_d;
   logic [SRC_W-1:0]     gnt_idx;
   logic                 any_req;
   logic                 pause_w;

`ifdef DISP_SCHED_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_arb (
      .req     (src_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

   always_comb begin
      state_d   = state_q;
      cur_src_d = cur_src_q;
      rr_ptr_d  = rr_ptr_q;
      timer_d   = timer_q;
      din_d     = din_q;
      en_d      = 1'b0;
      ack_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_req && !pause_w) begin
               cur_src_d = gnt_idx;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A source that withdrew between grant and load is skipped without a strobe.
            if (src_valid[cur_src_q]) begin
               din_d            = src_data[DISP_DW*cur_src_q +: DISP_DW];
               en_d             = 1'b1;
               ack_d[cur_src_q] = 1'b1;
               rr_ptr_d         = SRC_W'((int'(cur_src_q) + 1) % NUM_SRC);
               timer_d          = '0;
               state_d          = ST_HOLD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!pause_w) begin
               if (timer_q == HOLD_LAST) begin
                  if (any_req) begin
                     cur_src_d = gnt_idx;
                     state_d   = ST_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge disp_clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_src_q <= '0;
         rr_ptr_q  <= '0;
         timer_q   <= '0;
         din_q     <= '0;
         en_q      <= 1'b0;
         ack_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_src_q <= cur_src_d;
         rr_ptr_q  <= rr_ptr_d;
         timer_q   <= timer_d;
         din_q     <= din_d;
         en_q      <= en_d;
         ack_q     <= ack_d;
      end
   end

   assign src_ack  = ack_q;
   assign disp_din = din_q;
   assign disp_en  = en_q;
   assign cur_src  = cur_src_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed + random bench for disp_scheduler (NUM_SRC=4, HOLD_CYCLES=4) against a grant/dwell model.
module tb_disp_scheduler;

   localparam int NS = 4;
   localparam int HC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  src_valid = '0;
   logic [31:0] src_data = '0;
   logic        pause = 1'b0;
   logic [3:0]  src_ack;
   logic [7:0]  disp_din;
   logic        disp_en;
   logic [1:0]  cur_src;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int last_en = 0;
   int last_gap = 0;
   int exp_gap;
   int n_before;
   logic [7:0] obs_din[$];
   int         obs_cur[$];
   int         t3_exp[5] = '{10, 20, 30, 40, 10};

   // Reference model: pending load, countdown to next arbitration, rotation pointer.
   int         m_ptr, m_wait, m_load, e_cur;
   logic       e_en;
   logic [3:0] e_ack;
   logic [7:0] e_din;

   disp_scheduler #(
      .NUM_SRC     (NS),
      .HOLD_CYCLES (HC)
   ) dut (
      .disp_clk  (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ack   (src_ack),
      .disp_din  (disp_din),
      .disp_en   (disp_en),
      .cur_src   (cur_src)
`ifdef DISP_SCHED_PAUSE_EN
      ,
      .pause     (pause)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_ptr = 0; m_wait = 0; m_load = -1; e_cur = 0;
      e_en = 1'b0; e_ack = '0; e_din = '0;
   endfunction

   function automatic void model_step();
      logic p = 1'b0;
`ifdef DISP_SCHED_PAUSE_EN
      p = pause;
`endif
      e_en  = 1'b0;
      e_ack = '0;
      if (m_load >= 0) begin
         if (src_valid[m_load]) begin
            e_en   = 1'b1;
            e_ack  = 4'(1 << m_load);
            e_din  = src_data[8*m_load +: 8];
            m_ptr  = (m_load + 1) % NS;
            m_wait = HC - 1;
         end
         m_load = -1;
      end else if (p) begin
      end else if (m_wait > 0) begin
         m_wait--;
      end else begin
         for (int k = 0; k < NS; k++) begin
            int idx = (m_ptr + k) % NS;
            if (src_valid[idx]) begin
               m_load = idx;
               e_cur  = idx;
               break;
            end
         end
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      cycle++;
      if (!rst) begin
         check("en_ack", 32'({disp_en, src_ack}), 32'({e_en, e_ack}));
         check("din_cur", 32'({disp_din, cur_src}), 32'({e_din, e_cur[1:0]}));
         if (disp_en) begin
            obs_din.push_back(disp_din);
            obs_cur.push_back(int'(cur_src));
            last_gap = cycle - last_en;
            last_en  = cycle;
         end
      end
   endtask

   task automatic wait_en(input int limit, input string tag);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!disp_en && n < limit);
      check(tag, 32'(disp_en), 32'd1);
   endtask

   initial begin
      model_reset();
      // 1. reset and idle
      repeat (2) cyc();
      check("rst_vals", 32'({disp_en, src_ack, disp_din, cur_src}), 32'd0);
      rst = 1'b0;
      repeat (20) begin
         cyc();
         check("idle", 32'({disp_en, src_ack, disp_din, cur_src}), 32'd0);
      end

      // 2. single source with a negative value
      src_data[23:16] = 8'hFB;
      src_valid = 4'b0100;
      cyc();
      check("t2_lat1", 32'(disp_en), 32'd0);
      cyc();
      check("t2_first", 32'({disp_en, src_ack, disp_din, cur_src}), 32'({1'b1, 4'b0100, 8'hFB, 2'd2}));
      repeat (3) begin
         repeat (4) cyc();
         cyc();
         check("t2_period", 32'({disp_en, src_ack, disp_din}), 32'({1'b1, 4'b0100, 8'hFB}));
      end
      src_valid = 4'b0000;
      repeat (8) cyc();

      // 3. full rotation from a fresh pointer
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      src_data  = {8'd40, 8'd30, 8'd20, 8'd10};
      src_valid = 4'b1111;
      obs_din.delete();
      repeat (5) wait_en(12, "t3_wait");
      for (int i = 0; i < 5; i++) check("t3_seq", 32'(obs_din[i]), 32'(t3_exp[i]));
      check("t3_gap", 32'(last_gap), 32'(HC + 1));

      // 4. sparse requests, drop-out, then idle with held value
      src_valid = 4'b1010;
      obs_cur.delete();
      repeat (3) wait_en(12, "t4_wait");
      check("t4_g0", 32'(obs_cur[0]), 32'd1);
      check("t4_g1", 32'(obs_cur[1]), 32'd3);
      check("t4_g2", 32'(obs_cur[2]), 32'd1);
      src_valid = 4'b1000;
      obs_cur.delete();
      repeat (2) wait_en(12, "t4_wait2");
      check("t4_g3", 32'(obs_cur[0]), 32'd3);
      check("t4_g4", 32'(obs_cur[1]), 32'd3);
      src_valid = 4'b0000;
      repeat (10) cyc();
      check("t4_hold40", 32'({disp_en, disp_din}), 32'({1'b0, 8'd40}));

      // 5. grant aborted because valid dropped before the load cycle
      n_before  = obs_din.size();
      src_valid = 4'b0001;
      cyc();
      src_valid = 4'b0000;
      repeat (8) cyc();
      check("t5_noen", 32'(obs_din.size()), 32'(n_before));

      // 6. async reset mid-dwell, then dwell timing (with optional pause)
      src_data[23:16] = 8'h55;
      src_valid = 4'b0100;
      wait_en(12, "t6_wait");
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      check("t6_async", 32'({disp_en, src_ack, disp_din, cur_src}), 32'd0);
      cyc();
      rst = 1'b0;
      wait_en(12, "t6_wait2");
      cyc();
`ifdef DISP_SCHED_PAUSE_EN
      pause = 1'b1;
      repeat (10) cyc();
      pause = 1'b0;
      exp_gap = HC + 1 + 10;
`else
      exp_gap = HC + 1;
`endif
      wait_en(30, "t6_wait3");
      check("t6_gap", 32'(last_gap), 32'(exp_gap));
      src_valid = 4'b0000;
      repeat (8) cyc();

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) src_valid = 4'($urandom_range(0, 15));
         src_data = $urandom;
`ifdef DISP_SCHED_PAUSE_EN
         pause = ($urandom_range(0, 9) == 0);
`endif
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
